sram_axi_bridge: RTL

//  Converts the core's two sram-like ports (inst_*, data_*) into a single AXI3 master for the SoC interconnect.

---
 rtl/bridge_pkg.sv | 11 +
 rtl/axi_wstrb_gen.sv | 10 +
 rtl/sram_axi_bridge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg: FSM state type, fixed AXI3 field values and the byte-strobe helper
// shared by sram_axi_bridge and axi_wstrb_gen.
package bridge_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} bridge_state_t;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int INST_ID = 0;
    localparam int DATA_ID = 1;
    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        return size == 2'd0 ? 4'b0001 << addr_lo : size == 2'd1 ? 4'b0011 << addr_lo : 4'hf;
    endfunction
endpackage

// File: rtl/axi_wstrb_gen.sv
// axi_wstrb_gen: byte-lane write strobe from transfer size and low address bits.
module axi_wstrb_gen
    import bridge_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_wstrb
);
    assign o_wstrb = size_to_wstrb(i_size, i_addr_lo);
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the core's inst/data sram-like ports into one AXI3 master, one transaction at a time.
// Define BRIDGE_ADDR_MAP_EN to fold kseg0/kseg1 addresses onto physical addresses on araddr/awaddr.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inst_req,
    input  logic            i_inst_wr,
    input  logic [1:0]      i_inst_size,
    input  logic [31:0]     i_inst_addr,
    input  logic [31:0]     i_inst_wdata,
    output logic [31:0]     o_inst_rdata,
    output logic            o_inst_addr_ok,
    output logic            o_inst_data_ok,
    input  logic            i_data_req,
    input  logic            i_data_wr,
    input  logic [1:0]      i_data_size,
    input  logic [31:0]     i_data_addr,
    input  logic [31:0]     i_data_wdata,
    output logic [31:0]     o_data_rdata,
    output logic            o_data_addr_ok,
    output logic            o_data_data_ok,
    output logic [ID_W-1:0] o_arid,
    output logic [31:0]     o_araddr,
    output logic [3:0]      o_arlen,
    output logic [2:0]      o_arsize,
    output logic [1:0]      o_arburst,
    output logic [1:0]      o_arlock,
    output logic [3:0]      o_arcache,
    output logic [2:0]      o_arprot,
    output logic            o_arvalid,
    input  logic            i_arready,
    input  logic [ID_W-1:0] i_rid,
    input  logic [31:0]     i_rdata,
    input  logic [1:0]      i_rresp,
    input  logic            i_rlast,
    input  logic            i_rvalid,
    output logic            o_rready,
    output logic [ID_W-1:0] o_awid,
    output logic [31:0]     o_awaddr,
    output logic [3:0]      o_awlen,
    output logic [2:0]      o_awsize,
    output logic [1:0]      o_awburst,
    output logic [1:0]      o_awlock,
    output logic [3:0]      o_awcache,
    output logic [2:0]      o_awprot,
    output logic            o_awvalid,
    input  logic            i_awready,
    output logic [ID_W-1:0] o_wid,
    output logic [31:0]     o_wdata,
    output logic [3:0]      o_wstrb,
    output logic            o_wlast,
    output logic            o_wvalid,
    input  logic            i_wready,
    input  logic [ID_W-1:0] i_bid,
    input  logic [1:0]      i_bresp,
    input  logic            i_bvalid,
    output logic            o_bready
);
    bridge_state_t r_state;
    logic          r_src;
    logic          r_wr;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic          r_inst_data_ok, r_data_data_ok;
    logic          w_idle, w_req_wr, w_aw_done, w_w_done;
    logic [1:0]    w_req_size;
    logic [31:0]   w_req_addr, w_req_wdata, w_bus_addr;
    logic [ID_W-1:0] w_id;
    logic          w_unused;

    assign w_idle         = r_state == IDLE;
    assign o_data_addr_ok = w_idle && i_data_req;
    assign o_inst_addr_ok = w_idle && i_inst_req && !i_data_req;
    assign w_req_wr       = i_data_req ? i_data_wr    : i_inst_wr;
    assign w_req_size     = i_data_req ? i_data_size  : i_inst_size;
    assign w_req_addr     = i_data_req ? i_data_addr  : i_inst_addr;
    assign w_req_wdata    = i_data_req ? i_data_wdata : i_inst_wdata;
    // a channel counts as done once its valid has dropped or is handshaking now
    assign w_aw_done      = !r_awvalid || i_awready;
    assign w_w_done       = !r_wvalid || i_wready;

`ifdef BRIDGE_ADDR_MAP_EN
    assign w_bus_addr = r_addr[31:30] == 2'b10 ? {3'b000, r_addr[28:0]} : r_addr;
`else
    assign w_bus_addr = r_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_src          <= 1'b0;
            r_wr           <= 1'b0;
            r_size         <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rdata        <= '0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_data_req || i_inst_req) begin
                    r_src     <= i_data_req;
                    r_wr      <= w_req_wr;
                    r_size    <= w_req_size;
                    r_addr    <= w_req_addr;
                    r_wdata   <= w_req_wdata;
                    r_arvalid <= !w_req_wr;
                    r_awvalid <= w_req_wr;
                    r_wvalid  <= w_req_wr;
                    r_state   <= w_req_wr ? WR : RD_ADDR;
                end
                RD_ADDR: if (i_arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= RD_DATA;
                end
                RD_DATA: if (i_rvalid) begin
                    r_rready       <= 1'b0;
                    r_rdata        <= i_rdata;
                    r_inst_data_ok <= !r_src;
                    r_data_data_ok <= r_src;
                    r_state        <= RESP;
                end
                WR: begin
                    if (i_awready) r_awvalid <= 1'b0;
                    if (i_wready) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: if (i_bvalid) begin
                    r_bready       <= 1'b0;
                    r_inst_data_ok <= !r_src;
                    r_data_data_ok <= r_src;
                    r_state        <= RESP;
                end
                RESP: begin
                    r_inst_data_ok <= 1'b0;
                    r_data_data_ok <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    axi_wstrb_gen u_wstrb (
        .i_size   (r_size),
        .i_addr_lo(r_addr[1:0]),
        .o_wstrb  (o_wstrb)
    );

    assign w_id           = r_src ? ID_W'(DATA_ID) : ID_W'(INST_ID);
    assign o_inst_rdata   = r_rdata;
    assign o_data_rdata   = r_rdata;
    assign o_inst_data_ok = r_inst_data_ok;
    assign o_data_data_ok = r_data_data_ok;
    assign o_arid         = w_id;
    assign o_araddr       = w_bus_addr;
    assign o_arlen        = 4'd0;
    assign o_arsize       = {1'b0, r_size};
    assign o_arburst      = AXI_BURST_INCR;
    assign o_arlock       = 2'd0;
    assign o_arcache      = 4'd0;
    assign o_arprot       = 3'd0;
    assign o_arvalid      = r_arvalid;
    assign o_rready       = r_rready;
    assign o_awid         = w_id;
    assign o_awaddr       = w_bus_addr;
    assign o_awlen        = 4'd0;
    assign o_awsize       = {1'b0, r_size};
    assign o_awburst      = AXI_BURST_INCR;
    assign o_awlock       = 2'd0;
    assign o_awcache      = 4'd0;
    assign o_awprot       = 3'd0;
    assign o_awvalid      = r_awvalid;
    assign o_wid          = w_id;
    assign o_wdata        = r_wdata;
    assign o_wlast        = 1'b1;
    assign o_wvalid       = r_wvalid;
    assign o_bready       = r_bready;
    // response ids/status are deliberately ignored: no bus-error path back to the core
    assign w_unused       = ^{i_rid, i_rresp, i_rlast, i_bid, i_bresp, r_wr};
endmodule
